rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and a multi-cycle execution unit (mult/div). Writeback always has priority. Multi-cycle results wait in a small in-order queue and are issued on free cycles. A starvation guard requests a pipeline bubble when the queue is full and its head is too old. The block also reports pending queued writes to the hazard unit and resolves write-after-write conflicts in favour of writeback.

## Interface
- `QDEPTH`, 2: queue entries for multi-cycle results (2..4).
- `STARVE_LIMIT`, 4: cycles the queue head may wait while full before `pipe_stall` asserts.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `wb_en`  in  1  writeback write request (no backpressure).
- `wb_dest`  in  5  writeback destination register.
- `wb_val`  in  32  writeback data.
- `mc_valid`  in  1  multi-cycle result valid.
- `mc_dest`  in  5  multi-cycle destination register.
- `mc_val`  in  32  multi-cycle data.
- `mc_ready`  out  1  queue can accept; a result transfers when `mc_valid && mc_ready` at posedge.
- `rf_we`, `rf_dest`, `rf_val`  out  1/5/32  registered write command to the register file.
- `chk_src1`, `chk_src2`  in  5  decode-stage source registers.
- `chk_hit1`, `chk_hit2`  out  1  a live queued write targets that source register.
- `pipe_stall`  out  1  asks the pipeline to hold `wb_en` low.
- `q_count`  out  3  live plus dead entries in the queue.

## Operation
- Writes to register 0 are discarded at the input:
  - `wb_en` with `wb_dest == 0` counts as no request.
  - An accepted `mc` with `mc_dest == 0` completes its handshake but is not enqueued.
- Queue:
  - In-order FIFO. Each entry holds {live, dest, val}.
  - `mc_ready = (q_count < QDEPTH)`, taken from registered state. Nothing passes straight through a full queue, even on a cycle that dequeues.
- Per-cycle selection, with the result registered onto `rf_*`:
  - Valid writeback request: issue WB. `rf_we=1`, `rf_dest=wb_dest`, `rf_val=wb_val`.
  - No WB request and queue non-empty: pop the head. If the head is live, `rf_we=1` with its dest/val. If dead, `rf_we=0`; the cycle is consumed.
  - Otherwise `rf_we=0`. `rf_dest` and `rf_val` hold their last values.
- WAW resolution:
  - An issued WB write to register d marks every entry already in the queue with dest d as dead.
  - A result enqueued on the same edge is not killed.
- `chk_hitN = 1` when any live entry has `dest == chk_srcN` and `chk_srcN != 0`.
  - Combinational from queue state only.
  - Excludes the `mc` input of the current cycle.
- State machine; the age counter counts cycles in which the head is not popped:
  - IDLE: queue empty. Goes to PEND on an enqueue.
  - PEND: queue non-empty. Age counter runs while the queue is full and the head is blocked. Goes to FORCE when `age == STARVE_LIMIT-1` and blocked again. Goes to IDLE when the queue empties.
  - FORCE: `pipe_stall=1`. On the first cycle without a WB request, pop the head, clear the age counter, and go to PEND (or IDLE if the queue empties).
  - If `wb_en` arrives during FORCE, WB still wins. The block stays in FORCE; this is a contract violation, not an error.
- Reset (asserted at any time):
  - Queue cleared, age counter 0, state IDLE.
  - `rf_we=0`, `rf_dest=0`, `rf_val=0`, `mc_ready=1`, `pipe_stall=0`, `q_count=0`, `chk_hit*=0`.

## Timing
- WB latency: request at edge N appears on `rf_*` after edge N. The register file commits it on the following negedge.
- MC latency:
  - Minimum 2 edges: enqueue at N, issue at N+1.
  - Plus one edge per cycle the writeback stage holds the port.
- `pipe_stall` is registered. It asserts the cycle after the block enters FORCE and deasserts after the forced pop edge.
- Enqueue and pop on the same edge: `q_count` is unchanged and FIFO order is kept.
- Throughput: one register file write per cycle maximum.

## Test plan
- WB only: after reset, `wb_en=1`, `dest=5`, `val=0xA5A5A5A5` -> next cycle `rf_we=1`, `rf_dest=5`, `rf_val=0xA5A5A5A5`. `wb_dest=0` -> `rf_we=0`.
- MC on idle port: accept `mc dest=7`, `val=0x1234` at edge N -> `rf_we=1`, `rf_dest=7` after N+1. `chk_src1=7` gives `chk_hit1=1` only between N and N+1.
- Full queue: `QDEPTH=2` with 2 entries and `wb_en` held -> `mc_ready=0`. After 4 blocked cycles `pipe_stall=1`. Drop `wb_en` for one cycle -> head issued, `pipe_stall` clears, `q_count=1`.
- WAW kill: queue holds dest 9 (`val=1`), then WB to dest 9 (`val=2`) -> `rf_val=2` issued. The later pop gives `rf_we=0` and `chk_hit` for 9 clears at the WB edge. Register 9 ends at 2.
- Same-edge: an `mc` to dest 3 accepted on the same edge as WB to dest 3 -> the entry stays live and is issued later, so register 3 ends with the mc value. Enqueue and pop on one edge -> `q_count` unchanged.
- Reset mid-operation: 2 entries queued and FORCE active, then `rst=0` asynchronously -> all outputs at reset values immediately. After release, no stale writes are issued.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file write port between the pipeline
// writeback stage (always wins) and an in-order queue of multi-cycle results,
// with write-after-write kill, pending-write hazard lookup and a starvation
// guard that requests a pipeline bubble.
module rf_write_arbiter #(
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_val,
    input  logic        mc_valid,
    input  logic [4:0]  mc_dest,
    input  logic [31:0] mc_val,
    output logic        mc_ready,
    output logic        rf_we,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_val,
    input  logic [4:0]  chk_src1,
    input  logic [4:0]  chk_src2,
    output logic        chk_hit1,
    output logic        chk_hit2,
    output logic        pipe_stall,
    output logic [2:0]  q_count
);

    localparam int AW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_FORCE} state_t;

    state_t        state;
    logic [AW-1:0] age;

    // Queue storage, entry 0 is the head; pops shift toward the head.
    logic          q_live [QDEPTH];
    logic [4:0]    q_dest [QDEPTH];
    logic [31:0]   q_val  [QDEPTH];
    logic [2:0]    count;

    logic          n_live [QDEPTH];
    logic [4:0]    n_dest [QDEPTH];
    logic [31:0]   n_val  [QDEPTH];
    logic [2:0]    n_count;
    logic [2:0]    pop_count;

    logic wb_req, enq, pop, full, blocked;

    assign wb_req   = wb_en && (wb_dest != '0);
    assign mc_ready = (count < 3'(QDEPTH));
    assign enq      = mc_valid && mc_ready && (mc_dest != '0);
    assign pop      = !wb_req && (count != '0);
    assign full     = (count == 3'(QDEPTH));
    assign blocked  = wb_req && (count != '0);
    assign q_count  = count;

    // Next queue contents: WAW kill on existing entries, then pop, then enqueue
    // into the first free slot so a same-edge result is never killed.
    always_comb begin
        n_live    = q_live;
        n_dest    = q_dest;
        n_val     = q_val;
        pop_count = count;
        if (wb_req) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                if ((3'(i) < count) && (q_dest[i] == wb_dest)) n_live[i] = 1'b0;
            end
        end
        if (pop) begin
            for (int unsigned i = 0; i + 1 < QDEPTH; i++) begin
                n_live[i] = q_live[i+1];
                n_dest[i] = q_dest[i+1];
                n_val[i]  = q_val[i+1];
            end
            n_live[QDEPTH-1] = 1'b0;
            pop_count = count - 3'd1;
        end
        n_count = pop_count;
        if (enq) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                if (3'(i) == pop_count) begin
                    n_live[i] = 1'b1;
                    n_dest[i] = mc_dest;
                    n_val[i]  = mc_val;
                end
            end
            n_count = pop_count + 3'd1;
        end
    end

    // Queue state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_live[i] <= 1'b0;
                q_dest[i] <= '0;
                q_val[i]  <= '0;
            end
        end else begin
            count  <= n_count;
            q_live <= n_live;
            q_dest <= n_dest;
            q_val  <= n_val;
        end
    end

    // Registered write command: writeback first, else pop the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we   <= 1'b0;
            rf_dest <= '0;
            rf_val  <= '0;
        end else if (wb_req) begin
            rf_we   <= 1'b1;
            rf_dest <= wb_dest;
            rf_val  <= wb_val;
        end else if (pop) begin
            rf_we <= q_live[0];
            if (q_live[0]) begin
                rf_dest <= q_dest[0];
                rf_val  <= q_val[0];
            end
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Starvation guard: ages a full, blocked head and forces a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            age        <= '0;
            pipe_stall <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    age        <= '0;
                    pipe_stall <= 1'b0;
                    if (enq) state <= S_PEND;
                end
                S_PEND: begin
                    if (pop) begin
                        age   <= '0;
                        state <= (n_count == '0) ? S_IDLE : S_PEND;
                    end else if (full && blocked) begin
                        if (age == AW'(STARVE_LIMIT - 1)) begin
                            state      <= S_FORCE;
                            pipe_stall <= 1'b1;
                        end else begin
                            age <= age + 1'b1;
                        end
                    end
                end
                S_FORCE: begin
                    if (pop) begin
                        age        <= '0;
                        pipe_stall <= 1'b0;
                        state      <= (n_count == '0) ? S_IDLE : S_PEND;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    age        <= '0;
                    pipe_stall <= 1'b0;
                end
            endcase
        end
    end

    // Hazard lookup against live queued writes only.
    always_comb begin
        chk_hit1 = 1'b0;
        chk_hit2 = 1'b0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if ((3'(i) < count) && q_live[i]) begin
                if ((chk_src1 != '0) && (q_dest[i] == chk_src1)) chk_hit1 = 1'b1;
                if ((chk_src2 != '0) && (q_dest[i] == chk_src2)) chk_hit2 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a queue-based reference model
// compared on every negedge plus hand-computed literal checks.
module tb_rf_write_arbiter;

    localparam int QD  = 2;
    localparam int LIM = 4;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_val;
    logic        mc_valid;
    logic [4:0]  mc_dest;
    logic [31:0] mc_val;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_val;
    logic [4:0]  chk_src1;
    logic [4:0]  chk_src2;
    logic        chk_hit1;
    logic        chk_hit2;
    logic        pipe_stall;
    logic [2:0]  q_count;

    int total = 0;
    int bad   = 0;

    rf_write_arbiter #(.QDEPTH(QD), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
        .mc_valid(mc_valid), .mc_dest(mc_dest), .mc_val(mc_val),
        .mc_ready(mc_ready),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_val(rf_val),
        .chk_src1(chk_src1), .chk_src2(chk_src2),
        .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
        .pipe_stall(pipe_stall), .q_count(q_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        live;
        logic [4:0]  dest;
        logic [31:0] val;
    } ent_t;

    ent_t        mq[$];
    logic        m_we    = 1'b0;
    logic [4:0]  m_dest  = '0;
    logic [31:0] m_val   = '0;
    logic        m_stall = 1'b0;
    int          m_wait  = 0;

    task automatic model_step();
        ent_t head;
        bit   was_full;
        bit   room;
        bit   wbr;
        bit   popped;
        if (!rst) begin
            mq.delete();
            m_we = 0; m_dest = '0; m_val = '0; m_stall = 0; m_wait = 0;
            return;
        end
        was_full = (mq.size() == QD);
        room     = (mq.size() < QD);
        wbr      = wb_en && (wb_dest != 0);
        popped   = 0;
        if (wbr) begin
            m_we = 1; m_dest = wb_dest; m_val = wb_val;
            foreach (mq[i]) if (mq[i].dest == wb_dest) mq[i].live = 0;
        end else if (mq.size() > 0) begin
            head   = mq.pop_front();
            popped = 1;
            m_we   = head.live;
            if (head.live) begin
                m_dest = head.dest;
                m_val  = head.val;
            end
        end else begin
            m_we = 0;
        end
        if (popped) begin
            m_wait  = 0;
            m_stall = 0;
        end else if (was_full && wbr) begin
            if (m_wait >= LIM - 1) m_stall = 1;
            else m_wait++;
        end
        if (mc_valid && room && (mc_dest != 0)) begin
            head.live = 1; head.dest = mc_dest; head.val = mc_val;
            mq.push_back(head);
        end
    endtask

    function automatic logic m_hit(input logic [4:0] s);
        m_hit = 1'b0;
        foreach (mq[i]) if (mq[i].live && (mq[i].dest == s) && (s != 0)) m_hit = 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("rf_we",      32'(rf_we),      32'(m_we));
        chk("rf_dest",    32'(rf_dest),    32'(m_dest));
        chk("rf_val",     rf_val,          m_val);
        chk("mc_ready",   32'(mc_ready),   32'(mq.size() < QD));
        chk("q_count",    32'(q_count),    32'(mq.size()));
        chk("pipe_stall", 32'(pipe_stall), 32'(m_stall));
        chk("chk_hit1",   32'(chk_hit1),   32'(m_hit(chk_src1)));
        chk("chk_hit2",   32'(chk_hit2),   32'(m_hit(chk_src2)));
    end

    // Register file image built from the DUT's write commands.
    logic [31:0] rfm [32];
    initial begin
        for (int i = 0; i < 32; i++) rfm[i] = '0;
        forever begin
            @(negedge clk);
            if (rst && rf_we) rfm[rf_dest] = rf_val;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        wb_en = 0; wb_dest = '0; wb_val = '0;
        mc_valid = 0; mc_dest = '0; mc_val = '0;
    endtask

    task automatic lit_reset(input string tag);
        chk({tag, "_rf_we"},   32'(rf_we),      32'd0);
        chk({tag, "_rf_dest"}, 32'(rf_dest),    32'd0);
        chk({tag, "_rf_val"},  rf_val,          32'd0);
        chk({tag, "_ready"},   32'(mc_ready),   32'd1);
        chk({tag, "_qcount"},  32'(q_count),    32'd0);
        chk({tag, "_stall"},   32'(pipe_stall), 32'd0);
        chk({tag, "_hit1"},    32'(chk_hit1),   32'd0);
        chk({tag, "_hit2"},    32'(chk_hit2),   32'd0);
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        chk_src1 = '0; chk_src2 = '0;
        repeat (2) @(posedge clk);
        #2;
        lit_reset("por");
        rst = 1;

        // WB only
        wb_en = 1; wb_dest = 5; wb_val = 32'hA5A5A5A5;
        step();
        chk("wb_we",   32'(rf_we),   32'd1);
        chk("wb_dest", 32'(rf_dest), 32'd5);
        chk("wb_val",  rf_val,       32'hA5A5A5A5);
        wb_dest = 0;
        step();
        chk("wb0_we",   32'(rf_we),   32'd0);
        chk("wb0_hold", 32'(rf_dest), 32'd5);
        idle_inputs();

        // MC on idle port, plus dest-0 handshake that is dropped
        mc_valid = 1; mc_dest = 0; mc_val = 32'hDEAD;
        step();
        chk("mc0_qcount", 32'(q_count), 32'd0);
        mc_dest = 7; mc_val = 32'h1234;
        step();
        chk("mc_qcount", 32'(q_count), 32'd1);
        mc_valid = 0; chk_src1 = 7;
        #1;
        chk("mc_hit_live", 32'(chk_hit1), 32'd1);
        step();
        chk("mc_we",   32'(rf_we),   32'd1);
        chk("mc_dest", 32'(rf_dest), 32'd7);
        chk("mc_val",  rf_val,       32'h1234);
        #1;
        chk("mc_hit_gone", 32'(chk_hit1), 32'd0);

        // Full queue and starvation guard
        wb_en = 1; wb_dest = 10; wb_val = 32'd100;
        mc_valid = 1; mc_dest = 11; mc_val = 32'h11;
        step();
        mc_dest = 12; mc_val = 32'h12;
        step();
        mc_valid = 0;
        chk("full_ready",  32'(mc_ready), 32'd0);
        chk("full_qcount", 32'(q_count),  32'd2);
        repeat (3) step();
        chk("stall_early", 32'(pipe_stall), 32'd0);
        step();
        chk("stall_on", 32'(pipe_stall), 32'd1);
        step();
        chk("stall_wb_held", 32'(pipe_stall), 32'd1);
        wb_en = 0;
        step();
        chk("force_dest",   32'(rf_dest),    32'd11);
        chk("force_val",    rf_val,          32'h11);
        chk("force_stall",  32'(pipe_stall), 32'd0);
        chk("force_qcount", 32'(q_count),    32'd1);
        step();
        chk("drain_dest", 32'(rf_dest), 32'd12);
        chk("drain_q",    32'(q_count), 32'd0);

        // WAW kill
        wb_en = 1; wb_dest = 20; wb_val = 32'd0;
        mc_valid = 1; mc_dest = 9; mc_val = 32'd1;
        step();
        mc_valid = 0; wb_dest = 9; wb_val = 32'd2; chk_src2 = 9;
        #1;
        chk("waw_hit_before", 32'(chk_hit2), 32'd1);
        step();
        chk("waw_wb_val", rf_val, 32'd2);
        #1;
        chk("waw_hit_after", 32'(chk_hit2), 32'd0);
        chk("waw_q", 32'(q_count), 32'd1);
        wb_en = 0;
        step();
        chk("waw_dead_we", 32'(rf_we),   32'd0);
        chk("waw_q0",      32'(q_count), 32'd0);
        chk("waw_reg9",    rfm[9],       32'd2);

        // Same-edge WB and enqueue to the same register
        wb_en = 1; wb_dest = 3; wb_val = 32'h33;
        mc_valid = 1; mc_dest = 3; mc_val = 32'h44; chk_src1 = 3;
        step();
        mc_valid = 0; wb_en = 0;
        #1;
        chk("same_hit", 32'(chk_hit1), 32'd1);
        step();
        chk("same_val", rf_val, 32'h44);
        // Enqueue and pop on the same edge
        mc_valid = 1; mc_dest = 4; mc_val = 32'h40;
        step();
        chk("reg3_final", rfm[3], 32'h44);
        mc_dest = 6; mc_val = 32'h60;
        step();
        chk("enqpop_q",    32'(q_count), 32'd1);
        chk("enqpop_dest", 32'(rf_dest), 32'd4);
        mc_valid = 0;
        step();
        chk("enqpop_next", 32'(rf_dest), 32'd6);

        // Reset in the middle of FORCE
        wb_en = 1; wb_dest = 21; wb_val = 32'd7; chk_src1 = 22;
        mc_valid = 1; mc_dest = 22; mc_val = 32'h22;
        step();
        mc_dest = 23; mc_val = 32'h23;
        step();
        mc_valid = 0;
        repeat (4) step();
        chk("pre_rst_stall", 32'(pipe_stall), 32'd1);
        #1;
        rst = 0;
        idle_inputs();
        #1;
        lit_reset("async");
        step();
        step();
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_we", 32'(rf_we),   32'd0);
            chk("post_rst_q",  32'(q_count), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
